// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate L1 data-cache controller.
// Stalls the CPU on read misses and on every write while the fixed-latency memory works.
module dcache_controller #(
    parameter int INDEX_BITS  = 4,
    parameter int MEM_LATENCY = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_read,
    input  logic         cpu_write,
    input  logic [31:0]  cpu_address,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         stall,
    output logic         hit,
    output logic [31:0]  mem_address,
    output logic [31:0]  mem_wdata,
    output logic         mem_read,
    output logic         mem_write,
    input  logic [127:0] mem_line
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;
    localparam int CNT_W    = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_postReset;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [31:0]           r_data [LINES][4];

    logic [31:0]           w_lookAddr;
    logic [INDEX_BITS-1:0] w_lookIdx;
    logic [1:0]            w_lookOff;
    logic [TAG_BITS-1:0]   w_lookTag;
    logic                  w_lookHit;
    logic [31:0]           w_lookWord;
    logic [INDEX_BITS-1:0] w_latchIdx;
    logic                  w_lastCycle;
    logic                  w_accept;
    logic                  w_idleWrite;
    logic                  w_idleRead;
    logic                  w_unused;

    // In DONE the lookup follows the latched address so a fresh fill can be returned.
    assign w_lookAddr  = (r_state == DONE) ? r_addr : cpu_address;
    assign w_lookIdx   = w_lookAddr[INDEX_BITS+3:4];
    assign w_lookOff   = w_lookAddr[3:2];
    assign w_lookTag   = w_lookAddr[31:INDEX_BITS+4];
    assign w_lookHit   = r_valid[w_lookIdx] && (r_tag[w_lookIdx] == w_lookTag);
    assign w_lookWord  = r_data[w_lookIdx][w_lookOff];
    assign w_latchIdx  = r_addr[INDEX_BITS+3:4];
    assign w_lastCycle = (r_cnt == CNT_W'(MEM_LATENCY - 1));
    assign w_accept    = (r_state == IDLE) && !reset && !r_postReset;
    assign w_idleWrite = w_accept && cpu_write;
    assign w_idleRead  = w_accept && cpu_read && !cpu_write;
    assign w_unused    = &{1'b0, w_lookAddr[1:0], r_addr[1:0]};

    always_comb begin
        w_nextState = r_state;
        stall       = 1'b0;
        hit         = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = 32'h0;
        mem_wdata   = 32'h0;
        cpu_rdata   = 32'h0;
        case (r_state)
            IDLE: begin
                if (w_idleWrite) begin
                    stall       = 1'b1;
                    hit         = w_lookHit;
                    w_nextState = WRITE;
                end else if (w_idleRead) begin
                    hit = w_lookHit;
                    if (w_lookHit) begin
                        cpu_rdata = w_lookWord;
                    end else begin
                        stall       = 1'b1;
                        w_nextState = FILL;
                    end
                end
            end
            FILL: begin
                stall       = 1'b1;
                mem_read    = 1'b1;
                mem_address = {r_addr[31:4], 4'b0000};
                if (w_lastCycle) w_nextState = DONE;
            end
            WRITE: begin
                stall       = 1'b1;
                mem_write   = 1'b1;
                mem_address = {r_addr[31:2], 2'b00};
                mem_wdata   = r_wdata;
                if (w_lastCycle) w_nextState = DONE;
            end
            DONE: begin
                if (cpu_read && w_lookHit) cpu_rdata = w_lookWord;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
        // Reset silences every handshake immediately, even mid-transaction.
        if (reset) begin
            stall       = 1'b0;
            hit         = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            mem_address = 32'h0;
            mem_wdata   = 32'h0;
            cpu_rdata   = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_postReset <= 1'b1;
        end else begin
            r_state     <= w_nextState;
            r_postReset <= 1'b0;
            if ((r_state == FILL || r_state == WRITE) && !w_lastCycle)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_idleWrite || w_idleRead) begin
            r_addr  <= cpu_address;
            r_wdata <= cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_valid <= '0;
        else if (r_state == FILL && w_lastCycle)
            r_valid[w_latchIdx] <= 1'b1;
    end

    // Tag and data arrays carry no reset; validity alone decides whether they are used.
    always_ff @(posedge clk) begin
        if (!reset && r_state == FILL && w_lastCycle) begin
            r_tag[w_latchIdx] <= r_addr[31:INDEX_BITS+4];
            for (int w = 0; w < 4; w++)
                r_data[w_latchIdx][w] <= mem_line[32*w +: 32];
        end else if (w_idleWrite && w_lookHit) begin
            r_data[w_lookIdx][w_lookOff] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: the driver queues the expected outcome of each
// request and a negedge monitor checks it when the CPU is released.
module tb_dcache_controller;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_read;
    logic         cpu_write;
    logic [31:0]  cpu_address;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         stall;
    logic         hit;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic         mem_read;
    logic         mem_write;
    logic [127:0] mem_line = '0;

    int vectorCount = 0;
    int missCount   = 0;

    typedef struct {
        logic        isWrite;
        logic [31:0] rdata;
        logic        hitExp;
        int          stallCycles;
        int          memCycles;
        logic [31:0] memAddr;
        logic [31:0] memWdata;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] memWords [logic [31:0]];

    dcache_controller #(.INDEX_BITS(4), .MEM_LATENCY(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .stall       (stall),
        .hit         (hit),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_line    (mem_line)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (memWords.exists(addr)) return memWords[addr];
        return 32'hC0DE0000 + addr;
    endfunction

    // Main memory: untouched words read back as 0xC0DE0000 + address.
    always @(negedge clk) begin
        if (mem_write) memWords[mem_address] = mem_wdata;
        for (int w = 0; w < 4; w++)
            mem_line[32*w +: 32] = memWord({mem_address[31:4], 4'b0000} + 32'(4 * w));
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic isWrite, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expRdata,
                                 input logic expHit, input int expStall, input int expMem,
                                 input logic [31:0] expMemAddr);
        exp_t e;
        e.isWrite     = isWrite;
        e.rdata       = expRdata;
        e.hitExp      = expHit;
        e.stallCycles = expStall;
        e.memCycles   = expMem;
        e.memAddr     = expMemAddr;
        e.memWdata    = wdata;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        cpu_read    = !isWrite;
        cpu_write   = isWrite;
        cpu_address = addr;
        cpu_wdata   = wdata;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!stall) break;
        end
        checkOutput("stall released", {31'b0, stall}, 32'h0);
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    // Monitor: accumulates per-transaction activity and scores it on the release cycle.
    initial begin
        int   stallCnt = 0, readCnt = 0, writeCnt = 0, addrOk = 0, dataOk = 0;
        logic hitSeen = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset || !(cpu_read || cpu_write)) begin
                stallCnt = 0; readCnt = 0; writeCnt = 0; addrOk = 0; dataOk = 0;
                hitSeen  = 1'b0;
            end else begin
                if (hit) hitSeen = 1'b1;
                if (mem_read) readCnt++;
                if (mem_write) writeCnt++;
                if (expQ.size() > 0 && (mem_read || mem_write)) begin
                    if (mem_address == expQ[0].memAddr) addrOk++;
                    if (mem_write && mem_wdata == expQ[0].memWdata) dataOk++;
                end
                if (stall) begin
                    stallCnt++;
                end else if (expQ.size() == 0) begin
                    checkOutput("unexpected completion", cpu_address, 32'hFFFFFFFF);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("stall cycles", 32'(stallCnt), 32'(e.stallCycles));
                    checkOutput("hit", {31'b0, hitSeen}, {31'b0, e.hitExp});
                    checkOutput("mem_address cycles", 32'(addrOk), 32'(e.memCycles));
                    if (e.isWrite) begin
                        checkOutput("mem_write cycles", 32'(writeCnt), 32'(e.memCycles));
                        checkOutput("mem_wdata cycles", 32'(dataOk), 32'(e.memCycles));
                        checkOutput("mem_read during write", 32'(readCnt), 32'h0);
                    end else begin
                        checkOutput("mem_read cycles", 32'(readCnt), 32'(e.memCycles));
                        checkOutput("mem_write during read", 32'(writeCnt), 32'h0);
                        checkOutput("cpu_rdata", cpu_rdata, e.rdata);
                    end
                    stallCnt = 0; readCnt = 0; writeCnt = 0; addrOk = 0; dataOk = 0;
                    hitSeen  = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        cpu_read    = 1'b0;
        cpu_write   = 1'b0;
        cpu_address = 32'h0;
        cpu_wdata   = 32'h0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset stall", {31'b0, stall}, 32'h0);
        checkOutput("reset mem_read", {31'b0, mem_read}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("post-reset hit", {31'b0, hit}, 32'h0);
        checkOutput("post-reset mem_write", {31'b0, mem_write}, 32'h0);

        applyStimulus(1'b0, 32'h40,   32'h0,        32'hC0DE0040, 1'b0, 4, 3, 32'h40);
        applyStimulus(1'b0, 32'h44,   32'h0,        32'hC0DE0044, 1'b1, 0, 0, 32'h0);
        applyStimulus(1'b1, 32'h48,   32'hDEADBEEF, 32'h0,        1'b1, 4, 3, 32'h48);
        applyStimulus(1'b0, 32'h48,   32'h0,        32'hDEADBEEF, 1'b1, 0, 0, 32'h0);
        applyStimulus(1'b1, 32'h1000, 32'h12345678, 32'h0,        1'b0, 4, 3, 32'h1000);
        applyStimulus(1'b0, 32'h1000, 32'h0,        32'h12345678, 1'b0, 4, 3, 32'h1000);
        applyStimulus(1'b0, 32'h140,  32'h0,        32'hC0DE0140, 1'b0, 4, 3, 32'h140);
        applyStimulus(1'b0, 32'h40,   32'h0,        32'hC0DE0040, 1'b0, 4, 3, 32'h40);
        applyStimulus(1'b0, 32'h4C,   32'h0,        32'hC0DE004C, 1'b1, 0, 0, 32'h0);
        applyStimulus(1'b0, 32'h3FC,  32'h0,        32'hC0DE03FC, 1'b0, 4, 3, 32'h3F0);
        applyStimulus(1'b0, 32'h3F0,  32'h0,        32'hC0DE03F0, 1'b1, 0, 0, 32'h0);

        // Abort a fill of 0x80 with reset in its second FILL cycle.
        @(posedge clk);
        #1;
        cpu_read    = 1'b1;
        cpu_address = 32'h80;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        cpu_read = 1'b0;
        @(negedge clk);
        checkOutput("abort reset-cycle stall", {31'b0, stall}, 32'h0);
        checkOutput("abort reset-cycle mem_read", {31'b0, mem_read}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("abort next-cycle mem_read", {31'b0, mem_read}, 32'h0);
        applyStimulus(1'b0, 32'h80,   32'h0,        32'hC0DE0080, 1'b0, 4, 3, 32'h80);

        repeat (3) @(posedge clk);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
